// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch stage and the control unit:
//   - opcode constants
//   - br_op encodings
//   - NOP instruction word
//   - instruction field bit positions
//   - fetch state enum
//   - sign-extension helper
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes (ir[31:26])
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_LD     = 6'h01;
  localparam logic [5:0] OP_ST     = 6'h02;
  localparam logic [5:0] OP_BR     = 6'h03;
  localparam logic [5:0] OP_BMI    = 6'h04;
  localparam logic [5:0] OP_BPL    = 6'h05;
  localparam logic [5:0] OP_BZ     = 6'h06;
  localparam logic [5:0] OP_HALT   = 6'h24;
  localparam logic [5:0] OP_NOP    = 6'h25;
  localparam logic [5:0] OP_CALL   = 6'h26;

  // br_op encodings; any value with bit 2 set means "no branch"
  localparam logic [2:0] BROP_BR   = 3'b000;
  localparam logic [2:0] BROP_BMI  = 3'b001;
  localparam logic [2:0] BROP_BPL  = 3'b010;
  localparam logic [2:0] BROP_BZ   = 3'b011;
  localparam logic [2:0] BROP_NONE = 3'b100;

  // Reset contents of the instruction register
  localparam logic [31:0] NOP_INSTR = 32'h9400_0000;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNC_MSB   = 4;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } fetch_state_e;

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Combinational next-PC selection for the fetch stage.
// Ports:
//   br_op    in  3     branch select (000 BR, 001 BMI, 010 BPL, 011 BZ, 1xx none)
//   rs_neg   in  1     rs value MSB
//   rs_zero  in  1     rs value == 0
//   pc       in  PC_W  current program counter
//   imm16    in  16    branch offset, relative to pc+1
//   taken    out 1     branch condition satisfied
//   next_pc  out PC_W  pc+1 (+ sext(imm16) when taken), modulo 2^PC_W
// -----------------------------------------------------------------------------
module branch_resolve
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [2:0]      br_op,
  input  logic            rs_neg,
  input  logic            rs_zero,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm16,
  output logic            taken,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] imm_ext;

  always_comb begin
    taken = 1'b0;
    if (!br_op[2]) begin
      case (br_op)
        BROP_BR:  taken = 1'b1;
        BROP_BMI: taken = rs_neg;
        BROP_BPL: taken = ~rs_neg & ~rs_zero;
        BROP_BZ:  taken = rs_zero;
        default:  taken = 1'b0;
      endcase
    end
  end

  // Size cast of a signed value sign-extends to PC_W.
  assign imm_ext = PC_W'(signed'(imm16));
  assign seq_pc  = pc + PC_W'(1);
  assign next_pc = taken ? (seq_pc + imm_ext) : seq_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Holds the PC, fetches one instruction per rising edge of upd_pc from a
// variable-latency instruction memory, and presents decoded IR fields.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   upd_pc              level; rising edge requests next-PC update + fetch
//   br_op, rs_neg,
//   rs_zero             branch select and datapath flags, sampled on upd edge
//   imem_req/imem_addr  fetch request (held until imem_valid) and address
//   imem_rdata/valid    instruction word and its qualifier
//   pc                  current PC
//   ir_valid            IR holds the instruction at pc
//   opcode, rs, rt, rd,
//   func, imm16         decoded IR fields (combinational from IR)
//   seq_err             sticky: upd_pc edge seen outside READY
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_pc,
  input  logic [2:0]         br_op,
  input  logic               rs_neg,
  input  logic               rs_zero,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [PC_W-1:0]    pc,
  output logic               ir_valid,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         func,
  output logic [15:0]        imm16,
  output logic               seq_err
);

  fetch_state_e        state_q;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_d;
  logic [INSTR_W-1:0]  ir_q;
  logic                ir_valid_q;
  logic                seq_err_q;
  logic                upd_q;
  logic                imem_req_q;
  logic                upd_edge;
  logic                br_taken;

  assign upd_edge = upd_pc & ~upd_q;

  branch_resolve #(
    .PC_W (PC_W)
  ) u_branch_resolve (
    .br_op   (br_op),
    .rs_neg  (rs_neg),
    .rs_zero (rs_zero),
    .pc      (pc_q),
    .imm16   (ir_q[IMM_MSB:IMM_LSB]),
    .taken   (br_taken),
    .next_pc (pc_d)
  );

  // imem_req is a register so the asynchronous reset removes it at once,
  // which lets the memory see an abandoned request disappear immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= INSTR_W'(NOP_INSTR);
      ir_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
      upd_q      <= 1'b0;
      imem_req_q <= 1'b0;
    end else begin
      upd_q <= upd_pc;
      case (state_q)
        ST_BOOT: begin
          if (upd_edge) seq_err_q <= 1'b1;
          imem_req_q <= 1'b1;
          state_q    <= ST_FETCH;
        end
        ST_FETCH: begin
          // An update request mid-fetch is a sequencing error; the fetch
          // itself carries on untouched.
          if (upd_edge) seq_err_q <= 1'b1;
          if (imem_valid) begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
            imem_req_q <= 1'b0;
            state_q    <= ST_READY;
          end
        end
        ST_READY: begin
          if (upd_edge) begin
            pc_q       <= pc_d;
            ir_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir_valid  = ir_valid_q;
  assign seq_err   = seq_err_q;

  assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign rt     = ir_q[RT_MSB:RT_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign func   = ir_q[FUNC_MSB:FUNC_LSB];
  assign imm16  = ir_q[IMM_MSB:IMM_LSB];

  // br_taken is exposed by the resolver for the control unit's benefit;
  // the fetch stage only needs next_pc.
  logic unused_taken;
  assign unused_taken = br_taken;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed testbench for instr_fetch_unit: a hand-driven instruction memory
// walks the PC through a fixed sequence of branches with known outcomes.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        upd_pc;
  logic [2:0]  br_op;
  logic        rs_neg;
  logic        rs_zero;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] pc;
  logic        ir_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  func;
  logic [15:0] imm16;
  logic        seq_err;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(
    .PC_W     (32),
    .INSTR_W  (32),
    .RESET_PC (32'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_pc     (upd_pc),
    .br_op      (br_op),
    .rs_neg     (rs_neg),
    .rs_zero    (rs_zero),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .pc         (pc),
    .ir_valid   (ir_valid),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .func       (func),
    .imm16      (imm16),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Serve the outstanding fetch: 'waits' idle cycles, then one valid cycle.
  // Called at the negedge right after the request was raised.
  task automatic mem_fetch(input logic [31:0] instr, input int waits, input logic [31:0] addr);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", imem_req, 1'b1);
      chk("addr_wait", imem_addr, addr);
      chk("irv_wait", ir_valid, 1'b0);
      imem_valid = 1'b0;
      @(negedge clk);
    end
    chk("req", imem_req, 1'b1);
    chk("addr", imem_addr, addr);
    chk("irv_lo", ir_valid, 1'b0);
    imem_valid = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("irv_hi", ir_valid, 1'b1);
    chk("req_drop", imem_req, 1'b0);
    chk("imm", imm16, instr[15:0]);
    $display("fetch addr=%0h instr=%08h waits=%0d", addr, instr, waits);
  endtask

  // One-cycle upd_pc pulse with the given branch inputs, then fetch.
  task automatic upd_fetch(input logic [2:0] op, input logic neg, input logic zero,
                           input logic [31:0] exp_pc, input logic [31:0] instr, input int waits);
    upd_pc  = 1'b1;
    br_op   = op;
    rs_neg  = neg;
    rs_zero = zero;
    @(negedge clk);
    upd_pc  = 1'b0;
    br_op   = 3'b111;
    rs_neg  = ~neg;
    rs_zero = ~zero;
    chk("next_pc", pc, exp_pc);
    mem_fetch(instr, waits, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    upd_pc     = 1'b0;
    br_op      = 3'b100;
    rs_neg     = 1'b0;
    rs_zero    = 1'b0;
    imem_rdata = 32'h0;
    imem_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_irv", ir_valid, 1'b0);
    chk("rst_seq", seq_err, 1'b0);
    chk("rst_op", opcode, 6'h25);
    chk("rst_imm", imm16, 16'h0000);

    // First fetch: request appears one edge after release.
    rst_n = 1'b1;
    chk("boot_req", imem_req, 1'b0);
    @(negedge clk);
    mem_fetch(32'h0400_0005, 0, 32'd0);
    chk("op1", opcode, 6'h01);

    // Walk to pc=10, then fetch a fully populated word there.
    upd_fetch(3'b000, 1'b0, 1'b0, 32'd6, 32'h0400_0003, 0);
    upd_fetch(3'b000, 1'b0, 1'b0, 32'd10, 32'h8C6A_2813, 1);
    chk("dec_op", opcode, 6'h23);
    chk("dec_rs", rs, 5'd3);
    chk("dec_rt", rt, 5'd10);
    chk("dec_rd", rd, 5'd5);
    chk("dec_func", func, 5'h13);

    // No-branch with 3 wait states: address 11 held for 4 cycles.
    upd_fetch(3'b100, 1'b0, 1'b0, 32'd11, 32'h0400_0008, 3);
    upd_fetch(3'b000, 1'b0, 1'b0, 32'd20, 32'h0400_FFFC, 0);
    // BMI taken / not taken from pc=20 with imm -4.
    upd_fetch(3'b001, 1'b1, 1'b0, 32'd17, 32'h0400_0002, 2);
    upd_fetch(3'b000, 1'b0, 1'b0, 32'd20, 32'h0400_FFFC, 0);
    upd_fetch(3'b001, 1'b0, 1'b0, 32'd21, 32'h0400_FFEF, 0);
    upd_fetch(3'b000, 1'b0, 1'b0, 32'd5, 32'h0400_0010, 0);
    // BZ taken from pc=5 with imm 16, then BPL not taken on zero.
    upd_fetch(3'b011, 1'b0, 1'b1, 32'd22, 32'h0400_FFEE, 0);
    upd_fetch(3'b000, 1'b0, 1'b0, 32'd5, 32'h0400_0010, 0);
    upd_fetch(3'b010, 1'b0, 1'b1, 32'd6, 32'h0400_FFF8, 0);
    upd_fetch(3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0400_0000, 0);

    // Wrap-around with upd_pc held high for 5 cycles: one update only.
    upd_pc = 1'b1;
    br_op  = 3'b100;
    @(negedge clk);
    chk("wrap_pc", pc, 32'd0);
    chk("wrap_req", imem_req, 1'b1);
    imem_valid = 1'b1;
    imem_rdata = 32'h0400_0007;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("wrap_irv", ir_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_pc", pc, 32'd0);
      chk("hold_req", imem_req, 1'b0);
    end
    upd_pc = 1'b0;
    $display("hold upd_pc 5 cycles pc=%0h", pc);

    // imem_valid while READY must not disturb the IR.
    imem_valid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("ready_ign_imm", imm16, 16'h0007);
    chk("ready_ign_irv", ir_valid, 1'b1);
    chk("seq_clean", seq_err, 1'b0);

    // Second rising edge of upd_pc while still fetching.
    upd_pc = 1'b1;
    br_op  = 3'b000;
    @(negedge clk);
    upd_pc = 1'b0;
    br_op  = 3'b100;
    chk("seq_pc0", pc, 32'd8);
    @(negedge clk);
    upd_pc = 1'b1;
    br_op  = 3'b000;
    @(negedge clk);
    upd_pc = 1'b0;
    chk("seq_err", seq_err, 1'b1);
    chk("seq_pc", pc, 32'd8);
    chk("seq_req", imem_req, 1'b1);
    $display("seq_err test seq_err=%0b pc=%0h", seq_err, pc);

    // Asynchronous reset mid-fetch.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_pc", pc, 32'd0);
    chk("arst_op", opcode, 6'h25);
    chk("arst_imm", imm16, 16'h0000);
    chk("arst_irv", ir_valid, 1'b0);
    chk("arst_seq", seq_err, 1'b0);
    $display("async reset mid-fetch req=%0b pc=%0h", imem_req, pc);

    // Late imem_valid while in BOOT is ignored; fetch restarts at RESET_PC.
    @(negedge clk);
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    chk("reboot_req", imem_req, 1'b0);
    @(negedge clk);
    imem_valid = 1'b0;
    chk("boot_ign_op", opcode, 6'h25);
    mem_fetch(32'h0400_0005, 1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
